// File: rtl/bit_cpt3.sv
// 3-bit synchronous up-counter with count enable and synchronous active-low reset.
// Leaf counter primitive: increments once per clock while activate is high, wraps 7 -> 0.
module bit_cpt3 (
  input  logic       activate,
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] cpt
);

  localparam int WIDTH = 3;

  logic [WIDTH-1:0] cptNext;

  // Increment wraps naturally at the register width, so no saturation or flag logic.
  always_comb begin
    cptNext = cpt;
    if (activate) begin
      cptNext = cpt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cpt <= '0;
    end else begin
      cpt <= cptNext;
    end
  end

endmodule

// File: tb/tb_bit_cpt3.sv
// Self-checking bench for bit_cpt3: directed scenarios followed by random stimulus,
// all compared against an arithmetic reference count kept in the bench.
module tb_bit_cpt3;

  logic       clk;
  logic       reset;
  logic       activate;
  logic [2:0] cpt;

  int modelCount;
  int assertCount;
  int failCount;

  bit_cpt3 dut (
    .activate(activate),
    .clk     (clk),
    .reset   (reset),
    .cpt     (cpt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, take one rising edge, then advance the reference count by the same rule.
  task automatic applyStimulus(input logic rstVal, input logic actVal);
    reset    = rstVal;
    activate = actVal;
    @(posedge clk);
    #1;
    if (!rstVal) begin
      modelCount = 0;
    end else if (actVal) begin
      modelCount = (modelCount + 1) % 8;
    end
  endtask

  task automatic checkOutput(input string tag);
    assertCount++;
    assert (cpt === 3'(modelCount)) else begin
      failCount++;
      $error("[TB] FAIL %s: cpt=%0d expected=%0d", tag, cpt, modelCount);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int guard;
    logic r;
    logic a;

    assertCount = 0;
    failCount   = 0;
    modelCount  = 0;
    reset       = 1'b0;
    activate    = 1'b1;

    // Reset holds priority over activate.
    applyStimulus(1'b0, 1'b1);
    checkOutput("reset_edge1");
    applyStimulus(1'b0, 1'b1);
    checkOutput("reset_edge2");

    // Count from 0 until the counter reaches 4, bounded.
    guard = 0;
    while (modelCount < 4 && guard < 10) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput("count_up");
      guard++;
    end
    assertCount++;
    assert (modelCount == 4 && guard == 4) else begin
      failCount++;
      $error("[TB] FAIL count_steps: steps=%0d expected=4", guard);
    end

    // Hold at 3 for three edges, then re-enable.
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("pre_hold_3");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0);
      checkOutput("hold");
    end
    applyStimulus(1'b1, 1'b1);
    checkOutput("hold_release_4");

    // Wrap-around: nine enabled edges from 0.
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput("wrap");
    end

    // Mid-count reset at 5, then resume.
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1);
    checkOutput("pre_mid_5");
    applyStimulus(1'b0, 1'b1);
    checkOutput("mid_reset");
    applyStimulus(1'b1, 1'b1);
    checkOutput("mid_resume");

    // Reset pulse strictly between edges must not act.
    applyStimulus(1'b1, 1'b1);
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("glitch_reset_mid");
    applyStimulus(1'b1, 1'b1);
    checkOutput("glitch_reset_edge");

    // Activate pulse strictly between edges must not count.
    activate = 1'b0;
    #1;
    activate = 1'b1;
    #2;
    activate = 1'b0;
    #1;
    checkOutput("glitch_act_mid");
    applyStimulus(1'b1, 1'b0);
    checkOutput("glitch_act_edge");

    // Random sequence with occasional resets.
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 9) != 0);
      a = 1'($urandom_range(0, 1));
      applyStimulus(r, a);
      checkOutput("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
